free_list: RTL and testbench
============================

// Module: free_list
// PURPOSE
//  Circular FIFO of free physical register (PR) indices for R10000-style renaming.
//  - Sits directly upstream of the map table.
//  - Each dispatch cycle it supplies up to NUM_SUPER new PR tags (FL_Map_Table_out.T_idx).
//  - Reclaims T_old tags from retiring ROB entries.
//  - On rollback, restores to the "all non-architectural PRs free" state, matching the map table's restore from the arch map.
// PARAMETERS
//  NUM_PR     64  physical registers; PR idx width PRW = $clog2(NUM_PR)
//  NUM_ARCH   32  architectural registers; PRs 0..NUM_ARCH-1 are mapped at reset
//  NUM_SUPER  2   dispatch/retire lanes
//  DEPTH      NUM_PR-NUM_ARCH  FIFO entries; CW = $clog2(DEPTH+1)
// PORTS
//  clock            in   1                clock
//  reset            in   1                synchronous, active-high
//  en               in   1                global advance; when low, no state change
//  dispatch_en      in   1                dispatch group accepted this cycle
//  dest_valid       in   NUM_SUPER        lane has a non-ZERO_REG destination and needs a PR
//  retire_en        in   NUM_SUPER        lane retires and frees its T_old
//  retire_Told_idx  in   NUM_SUPER*PRW    T_old per retiring lane
//  rollback_en      in   1                pipeline flush (ROB stall_dispatch)
//  T_idx            out  NUM_SUPER*PRW    new PR tag per lane (FL_Map_Table_out)
//  free_cnt         out  CW               registered count of free entries
//  FL_stall         out  1                not enough free PRs for the current request
// BEHAVIOUR
//  - State: fl[DEPTH] of PRW bits; head and tail pointers ($clog2(DEPTH) bits, wrap modulo DEPTH); count (CW bits).
//  - Reset: fl[i] = NUM_ARCH+i, head = 0, tail = 0, count = DEPTH.
//    - Output values at reset: free_cnt = DEPTH, FL_stall = 0, T_idx[0] = NUM_ARCH, T_idx[1] = NUM_ARCH+1.
//  - Allocation is compacted:
//    - The k-th lane with dest_valid set receives fl[head+k].
//    - Lanes without dest_valid output fl[head+k] with k = count of valid lanes below them; this value is don't-care.
//    - T_idx is combinational from head and dest_valid; zero-cycle latency.
//  - need = popcount(dest_valid).
//  - FL_stall = (need > avail), where avail = count without the bypass macro.
//  - Pop occurs when dispatch_en && en && !FL_stall && !rollback_en: head += need; count -= need.
//    - Asserting dispatch_en while FL_stall is set is illegal. The block ignores the pop; there is no underflow.
//  - Push is compacted: the k-th retiring lane writes fl[tail+k] = retire_Told_idx[lane]; tail += popcount(retire_en).
//    - count + pushes > DEPTH is illegal; an assertion fires.
//  - Simultaneous pop and push: count_next = count - pops + pushes.
//    - The pop reads old array contents (read-before-write).
//  - Rollback (takes priority over dispatch):
//    - Same-cycle retires are pushed first.
//    - Then head_next = tail_next and count_next = DEPTH: every non-architectural PR is free again.
//  - Pointers wrap at DEPTH (DEPTH need not be a power of two; use an explicit compare-and-wrap).
//  - A reset asserted mid-operation overrides everything within the same edge.
// CONFIGURATION
//  FL_RETIRE_BYPASS_EN
//  - Defined:
//    - avail = count + popcount(retire_en).
//    - When count < need, lanes beyond count take the same-cycle retire_Told_idx in compacted order. This removes one stall cycle when the FIFO is empty.
//  - Undefined:
//    - avail = count.
//    - Retired tags become allocatable the cycle after retire.
// STRUCTURE
//  - Shared package holds: FL_MAP_TABLE_OUT_t {T_idx[NUM_SUPER]}, ROB_FL_OUT_t {retire_en, Told_idx}, NUM_PR, NUM_ARCH, `FL_RESET pattern.
//  - No sub-module. Use one function for compacted lane offsets (prefix popcount) and one for pointer wrap.
// TESTING
//  - Reset, then dest_valid=2'b11 with dispatch_en -> T_idx=32,33; next cycle free_cnt=30 and T_idx=34,35.
//  - dest_valid=2'b10 -> lane1 gets 32, head advances by 1, free_cnt=31.
//  - Drain to free_cnt=1 with dest_valid=2'b11 -> FL_stall=1, no pop.
//    - Retire Told=5 -> next cycle free_cnt=2, FL_stall=0.
//    - With FL_RETIRE_BYPASS_EN the stall clears in the same cycle and lane1 gets 5.
//  - Pop 2 + retire 2 (Told=7,9) in the same cycle -> free_cnt unchanged; 7,9 are allocated after the existing entries in FIFO order.
//  - Wrap: 20 cycles of 2-pop/2-push -> head/tail wrap past DEPTH-1; no lost or duplicate tags (scoreboard).
//  - Rollback with free_cnt=10 plus one retire -> next cycle free_cnt=32; the following dispatch begins at old_tail+1.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared types, sizes and helpers for the free physical-register list.
// Lane-compaction and pointer-wrap helpers live here so the bench can reuse sizes.
package free_list_pkg;

    localparam int NUM_PR    = 64;
    localparam int NUM_ARCH  = 32;
    localparam int NUM_SUPER = 2;
    localparam int PRW       = $clog2(NUM_PR);
    localparam int DEPTH     = NUM_PR - NUM_ARCH;
    localparam int CW        = $clog2(DEPTH + 1);
    localparam int PTRW      = $clog2(DEPTH);
    localparam int NW        = $clog2(NUM_SUPER + 1);

    typedef struct packed {
        logic [NUM_SUPER-1:0][PRW-1:0] T_idx;
    } FL_MAP_TABLE_OUT_t;

    typedef struct packed {
        logic [NUM_SUPER-1:0]          retire_en;
        logic [NUM_SUPER-1:0][PRW-1:0] Told_idx;
    } ROB_FL_OUT_t;

    // Entry i of the list holds the i-th non-architectural PR after reset.
    function automatic logic [PRW-1:0] fl_reset(input int i);
        return PRW'(NUM_ARCH + i);
    endfunction

    function automatic logic [NW-1:0] popcnt(input logic [NUM_SUPER-1:0] m);
        logic [NW-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_SUPER; i++)
            c = c + NW'(m[i]);
        return c;
    endfunction

    // Number of set lanes strictly below `lane`.
    function automatic logic [NW-1:0] lane_off(input logic [NUM_SUPER-1:0] m,
                                               input int lane);
        logic [NW-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_SUPER; i++)
            if (i < lane)
                c = c + NW'(m[i]);
        return c;
    endfunction

    function automatic logic [PTRW-1:0] ptr_add(input logic [PTRW-1:0] p,
                                                input logic [NW-1:0] k);
        logic [PTRW:0] s;
        s = {1'b0, p} + (PTRW+1)'(k);
        if (s >= (PTRW+1)'(DEPTH))
            s = s - (PTRW+1)'(DEPTH);
        return s[PTRW-1:0];
    endfunction

    // T_old of the n-th retiring lane in compacted order.
    function automatic logic [PRW-1:0] nth_told(input ROB_FL_OUT_t r,
                                                input logic [NW-1:0] n);
        logic [PRW-1:0] t;
        t = '0;
        for (int i = 0; i < NUM_SUPER; i++)
            if (r.retire_en[i] && lane_off(r.retire_en, i) == n)
                t = r.Told_idx[i];
        return t;
    endfunction

endpackage

// File: rtl/free_list.sv
// Circular FIFO of free physical-register tags for R10000-style renaming.
// Define FL_RETIRE_BYPASS_EN to let same-cycle retires feed allocation.
module free_list
    import free_list_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     dispatch_en,
    input  logic [NUM_SUPER-1:0]     dest_valid,
    input  logic [NUM_SUPER-1:0]     retire_en,
    input  logic [NUM_SUPER*PRW-1:0] retire_Told_idx,
    input  logic                     rollback_en,
    output logic [NUM_SUPER*PRW-1:0] T_idx,
    output logic [CW-1:0]            free_cnt,
    output logic                     FL_stall
);

    logic [PRW-1:0]    fl [DEPTH];
    logic [PTRW-1:0]   head;
    logic [PTRW-1:0]   tail;
    logic [PTRW-1:0]   tail_nxt;
    logic [CW-1:0]     count;
    logic [CW-1:0]     avail;
    logic [NW-1:0]     need;
    logic [NW-1:0]     pushes;
    logic [NW-1:0]     pops;
    logic              pop;
    ROB_FL_OUT_t       rob_in;
    FL_MAP_TABLE_OUT_t fl_out;

    assign rob_in   = {retire_en, retire_Told_idx};
    assign need     = popcnt(dest_valid);
    assign pushes   = popcnt(rob_in.retire_en);
    assign tail_nxt = ptr_add(tail, pushes);

`ifdef FL_RETIRE_BYPASS_EN
    assign avail = count + CW'(pushes);
`else
    assign avail = count;
`endif

    assign FL_stall = CW'(need) > avail;
    assign pop      = dispatch_en && en && !FL_stall && !rollback_en;
    assign pops     = pop ? need : NW'(0);
    assign free_cnt = count;
    assign T_idx    = fl_out;

    always_comb begin
        fl_out = '0;
        for (int l = 0; l < NUM_SUPER; l++) begin
            fl_out.T_idx[l] = fl[ptr_add(head, lane_off(dest_valid, l))];
`ifdef FL_RETIRE_BYPASS_EN
            // Past the stored entries, lanes pick up tags retiring this cycle.
            if (CW'(lane_off(dest_valid, l)) >= count)
                fl_out.T_idx[l] = nth_told(rob_in,
                    NW'(CW'(lane_off(dest_valid, l)) - count));
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                fl[i] <= fl_reset(i);
            head  <= '0;
            tail  <= '0;
            count <= CW'(DEPTH);
        end else if (en) begin
            for (int l = 0; l < NUM_SUPER; l++)
                if (rob_in.retire_en[l])
                    fl[ptr_add(tail, lane_off(rob_in.retire_en, l))]
                        <= rob_in.Told_idx[l];
            tail <= tail_nxt;
            if (rollback_en) begin
                head  <= tail_nxt;
                count <= CW'(DEPTH);
            end else begin
                head  <= ptr_add(head, pops);
                count <= count - CW'(pops) + CW'(pushes);
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset && en)
            assert ((CW+1)'(count) + (CW+1)'(pushes) <= (CW+1)'(DEPTH))
            else $error("free list overflow on retire");
    end
`endif

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list with a queue-based model of the free pool.
// Honours FL_RETIRE_BYPASS_EN the same way as the design.
module tb_free_list;
    import free_list_pkg::*;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     en;
    logic                     dispatch_en;
    logic [NUM_SUPER-1:0]     dest_valid;
    logic [NUM_SUPER-1:0]     retire_en;
    logic [NUM_SUPER*PRW-1:0] retire_Told_idx;
    logic                     rollback_en;
    logic [NUM_SUPER*PRW-1:0] T_idx;
    logic [CW-1:0]            free_cnt;
    logic                     FL_stall;

    free_list dut (
        .clock           (clock),
        .reset           (reset),
        .en              (en),
        .dispatch_en     (dispatch_en),
        .dest_valid      (dest_valid),
        .retire_en       (retire_en),
        .retire_Told_idx (retire_Told_idx),
        .rollback_en     (rollback_en),
        .T_idx           (T_idx),
        .free_cnt        (free_cnt),
        .FL_stall        (FL_stall)
    );

    always #5 clock = ~clock;

    int fq[$];
    int hist[$];
    int infl[$];
    int exp_t[NUM_SUPER];
    bit exp_stall;
    int n_cmp = 0;
    int n_bad = 0;

    function automatic int tout(input int l);
        return int'(T_idx[l*PRW +: PRW]);
    endfunction

    function automatic int told(input int l);
        return int'(retire_Told_idx[l*PRW +: PRW]);
    endfunction

    function automatic int cnt_bits(input logic [NUM_SUPER-1:0] m);
        int c = 0;
        for (int i = 0; i < NUM_SUPER; i++) c += int'(m[i]);
        return c;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        hist.delete();
        for (int i = 0; i < DEPTH; i++) begin
            fq.push_back(NUM_ARCH + i);
            hist.push_back(NUM_ARCH + i);
        end
    endtask

    task automatic model_check();
        int a[$];
        int k;
        if (reset) return;
        a = fq;
`ifdef FL_RETIRE_BYPASS_EN
        for (int l = 0; l < NUM_SUPER; l++)
            if (retire_en[l]) a.push_back(told(l));
`endif
        exp_stall = cnt_bits(dest_valid) > a.size();
        chk("free_cnt", int'(free_cnt), fq.size());
        chk("FL_stall", int'(FL_stall), int'(exp_stall));
        k = 0;
        for (int l = 0; l < NUM_SUPER; l++) begin
            if (dest_valid[l]) begin
                if (k < a.size()) begin
                    exp_t[l] = a[k];
                    chk("T_idx", tout(l), a[k]);
                end
                k++;
            end
        end
    endtask

    task automatic model_update();
        int npop;
        if (reset) begin
            model_reset();
            return;
        end
        if (!en) return;
        for (int l = 0; l < NUM_SUPER; l++) begin
            if (retire_en[l]) begin
                fq.push_back(told(l));
                hist.push_back(told(l));
                if (hist.size() > DEPTH) void'(hist.pop_front());
            end
        end
        if (rollback_en) begin
            fq = hist;
        end else begin
            npop = (dispatch_en && !exp_stall) ? cnt_bits(dest_valid) : 0;
            repeat (npop) void'(fq.pop_front());
        end
    endtask

    task automatic drive(input bit r, input bit e, input bit de,
                         input logic [1:0] dv, input logic [1:0] re,
                         input int t0, input int t1, input bit rb);
        reset           = r;
        en              = e;
        dispatch_en     = de;
        dest_valid      = dv;
        retire_en       = re;
        retire_Told_idx = {PRW'(t1), PRW'(t0)};
        rollback_en     = rb;
        @(negedge clock);
        model_check();
    endtask

    task automatic tick();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic step(input bit de, input logic [1:0] dv,
                        input logic [1:0] re, input int t0, input int t1);
        drive(0, 1, de, dv, re, t0, t1, 0);
        tick();
    endtask

    task automatic do_reset();
        drive(1, 1, 1, 2'b11, 2'b11, 1, 2, 0);
        tick();
    endtask

    initial begin
        exp_t = '{default: 0};
        drive(1, 1, 0, 2'b11, 2'b00, 0, 0, 0);
        tick();
        do_reset();

        drive(0, 1, 0, 2'b11, 2'b00, 0, 0, 0);
        chk("rst_free_cnt", int'(free_cnt), 32);
        chk("rst_stall", int'(FL_stall), 0);
        chk("rst_t0", tout(0), 32);
        chk("rst_t1", tout(1), 33);
        tick();
        drive(0, 1, 1, 2'b11, 2'b00, 0, 0, 0);
        chk("pop2_t0", tout(0), 32);
        chk("pop2_t1", tout(1), 33);
        tick();
        drive(0, 1, 0, 2'b11, 2'b00, 0, 0, 0);
        chk("pop2_cnt", int'(free_cnt), 30);
        chk("pop2_next_t0", tout(0), 34);
        chk("pop2_next_t1", tout(1), 35);
        tick();

        do_reset();
        drive(0, 1, 1, 2'b10, 2'b00, 0, 0, 0);
        chk("dv10_t1", tout(1), 32);
        tick();
        drive(0, 1, 0, 2'b11, 2'b00, 0, 0, 0);
        chk("dv10_cnt", int'(free_cnt), 31);
        chk("dv10_next_t0", tout(0), 33);
        tick();
        repeat (15) step(1, 2'b11, 2'b00, 0, 0);
        drive(0, 1, 1, 2'b11, 2'b00, 0, 0, 0);
        chk("drain_cnt", int'(free_cnt), 1);
        chk("drain_stall", int'(FL_stall), 1);
        tick();
        drive(0, 1, 0, 2'b11, 2'b00, 0, 0, 0);
        chk("stall_no_pop", int'(free_cnt), 1);
        tick();
`ifdef FL_RETIRE_BYPASS_EN
        drive(0, 1, 1, 2'b11, 2'b01, 5, 0, 0);
        chk("byp_stall", int'(FL_stall), 0);
        chk("byp_t0", tout(0), 63);
        chk("byp_t1", tout(1), 5);
        tick();
        drive(0, 1, 0, 2'b11, 2'b00, 0, 0, 0);
        chk("byp_cnt", int'(free_cnt), 0);
        tick();
`else
        drive(0, 1, 0, 2'b11, 2'b01, 5, 0, 0);
        chk("ret_stall", int'(FL_stall), 1);
        tick();
        drive(0, 1, 0, 2'b11, 2'b00, 0, 0, 0);
        chk("ret_cnt", int'(free_cnt), 2);
        chk("ret_stall_clr", int'(FL_stall), 0);
        tick();
`endif

        do_reset();
        step(1, 2'b11, 2'b00, 0, 0);
        drive(0, 1, 1, 2'b11, 2'b11, 7, 9, 0);
        chk("pp_t0", tout(0), 34);
        chk("pp_t1", tout(1), 35);
        tick();
        drive(0, 1, 0, 2'b11, 2'b00, 0, 0, 0);
        chk("pp_cnt", int'(free_cnt), 30);
        tick();
        repeat (14) step(1, 2'b11, 2'b00, 0, 0);
        drive(0, 1, 1, 2'b11, 2'b00, 0, 0, 0);
        chk("pp_order_t0", tout(0), 7);
        chk("pp_order_t1", tout(1), 9);
        tick();

        do_reset();
        drive(0, 1, 1, 2'b11, 2'b00, 0, 0, 0);
        tick();
        infl.delete();
        infl.push_back(exp_t[0]);
        infl.push_back(exp_t[1]);
        for (int c = 0; c < 20; c++) begin
            drive(0, 1, 1, 2'b11, 2'b11, infl[0], infl[1], 0);
            for (int l = 0; l < NUM_SUPER; l++) begin
                int hit = 0;
                foreach (infl[j]) if (infl[j] == tout(l)) hit = 1;
                chk("wrap_dup", hit, 0);
            end
            tick();
            void'(infl.pop_front());
            void'(infl.pop_front());
            infl.push_back(exp_t[0]);
            infl.push_back(exp_t[1]);
        end
        drive(0, 1, 0, 2'b11, 2'b00, 0, 0, 0);
        chk("wrap_cnt", int'(free_cnt), 30);
        tick();

        do_reset();
        repeat (11) step(1, 2'b11, 2'b00, 0, 0);
        drive(0, 1, 1, 2'b11, 2'b01, 3, 0, 1);
        chk("rb_pre_cnt", int'(free_cnt), 10);
        tick();
        drive(0, 1, 0, 2'b11, 2'b00, 0, 0, 0);
        chk("rb_cnt", int'(free_cnt), 32);
        chk("rb_t0", tout(0), 33);
        chk("rb_t1", tout(1), 34);
        tick();
        drive(0, 0, 1, 2'b11, 2'b00, 0, 0, 0);
        tick();
        drive(0, 1, 0, 2'b11, 2'b00, 0, 0, 0);
        chk("en_low_cnt", int'(free_cnt), 32);
        chk("en_low_t0", tout(0), 33);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
